// File: rtl/snake_pkg.sv
// snake_pkg: shared game-state encoding, board constants and step-period helper.
package snake_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, OVER, WIN} game_state_t;
  localparam int BOARD_CELLS = 140;
  localparam int MAX_SPEED_LVL = 7;
  localparam int AUTO_RESTART_FRAMES = 120;
  // max(base - lvl*dec, min_p) without unsigned wrap-around
  function automatic logic [31:0] step_period(input logic [2:0] lvl, input logic [31:0] base, dec, min_p);
    logic [31:0] d;
    d = 32'(lvl) * dec;
    return (base > d && base - d > min_p) ? base - d : min_p;
  endfunction
endpackage

// File: rtl/game_flow_sequencer_step_timer.sv
// step_timer: period timer with pending flag; releases one step per frame boundary.
module step_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic        frame_done,
  input  logic [31:0] period,
  output logic        step
);
  logic [31:0] timer;
  logic pending;
  logic hit;
  assign hit = pending | (timer >= period);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      timer   <= '0;
      pending <= 1'b0;
      step    <= 1'b0;
    end else if (clr) begin
      timer   <= '0;
      pending <= 1'b0;
      step    <= 1'b0;
    end else if (!en) begin
      step    <= 1'b0;
    end else if (hit && frame_done) begin
      step    <= 1'b1;
      timer   <= '0;
      pending <= 1'b0;
    end else begin
      step    <= 1'b0;
      pending <= hit;
      timer   <= hit ? timer : timer + 32'd1;
    end
endmodule

// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer: snake game-flow FSM, frame-aligned step pulses and score-driven speed.
// SEQ_AUTO_RESTART_EN: OVER/WIN fall back to CLEAR after AUTO_RESTART_FRAMES frames.
module game_flow_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD   = 2_000_000,
  parameter int unsigned PERIOD_DEC    = 200_000,
  parameter int unsigned MIN_PERIOD    = 500_000,
  parameter int unsigned SCORE_PER_LVL = 5,
  parameter int unsigned WIN_SCORE     = 137,
  parameter int unsigned CLEAR_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_req,
  input  logic        pause_req,
  input  logic        frame_done,
  input  logic        good_coll,
  input  logic        bad_coll,
  input  logic [7:0]  score,
  output logic        step,
  output logic        soft_rst,
  output game_state_t state,
  output logic        game_over,
  output logic        game_won,
  output logic [2:0]  speed_lvl
);
  localparam int CW = $clog2(CLEAR_CYCLES) + 1;
  game_state_t next_state;
  logic [CW-1:0] clr_cnt;
  logic run_en, soft_rst_d, over_d, won_d, auto_restart;
  logic [2:0] lvl_d;
  logic [31:0] period;
  logic unused_good_coll;
  assign unused_good_coll = good_coll;
  assign period = step_period(speed_lvl, BASE_PERIOD, PERIOD_DEC, MIN_PERIOD);
`ifdef SEQ_AUTO_RESTART_EN
  localparam int FW = $clog2(AUTO_RESTART_FRAMES);
  logic [FW-1:0] frm_cnt;
  assign auto_restart = frame_done && frm_cnt == FW'(AUTO_RESTART_FRAMES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) frm_cnt <= '0;
    else frm_cnt <= (state == OVER || state == WIN) ? frm_cnt + FW'(frame_done) : '0;
`else
  assign auto_restart = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      soft_rst  <= 1'b0;
      game_over <= 1'b0;
      game_won  <= 1'b0;
      speed_lvl <= 3'd0;
    end else begin
      state     <= next_state;
      clr_cnt   <= (state == CLEAR) ? clr_cnt + CW'(1) : '0;
      soft_rst  <= soft_rst_d;
      game_over <= over_d;
      game_won  <= won_d;
      speed_lvl <= lvl_d;
    end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      next_state = start_req ? CLEAR : IDLE;
      CLEAR:     next_state = (clr_cnt == CW'(CLEAR_CYCLES - 1)) ? RUN : CLEAR;
      RUN:       next_state = bad_coll ? OVER : (32'(score) >= WIN_SCORE) ? WIN : pause_req ? PAUSE : RUN;
      PAUSE:     next_state = start_req ? CLEAR : pause_req ? RUN : PAUSE;
      OVER, WIN: next_state = (start_req || auto_restart) ? CLEAR : state;
      default:   next_state = IDLE;
    endcase
  end
  // a step on the cycle RUN is left is dropped by withholding enable
  always_comb begin
    soft_rst_d = next_state == CLEAR;
    over_d     = next_state == OVER;
    won_d      = next_state == WIN;
    run_en     = state == RUN && next_state == RUN;
    lvl_d      = step ? ((32'(score) >= MAX_SPEED_LVL * SCORE_PER_LVL) ? 3'(MAX_SPEED_LVL) : 3'(32'(score) / SCORE_PER_LVL))
               : (state == CLEAR) ? 3'd0 : speed_lvl;
  end
  step_timer u_step_timer (
    .clk       (clk),
    .reset     (reset),
    .en        (run_en),
    .clr       (state == CLEAR),
    .frame_done(frame_done),
    .period    (period),
    .step      (step)
  );
endmodule

// File: tb/tb_game_flow_sequencer.sv
// tb_game_flow_sequencer: directed vectors on a 30-cycle frame grid with hand-derived step times.
module tb_game_flow_sequencer;
  import snake_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_req = 1'b0, pause_req = 1'b0, frame_done = 1'b0, good_coll = 1'b0, bad_coll = 1'b0;
  logic [7:0] score = 8'd0;
  logic step, soft_rst, game_over, game_won;
  logic [2:0] speed_lvl;
  game_state_t state;
  int n_vec = 0, n_err = 0, ncnt = 0, last_step = -1, n_steps = 0;
  always #5 clk = ~clk;
  game_flow_sequencer #(.BASE_PERIOD(100), .PERIOD_DEC(10), .MIN_PERIOD(50)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .pause_req(pause_req), .frame_done(frame_done),
    .good_coll(good_coll), .bad_coll(bad_coll), .score(score), .step(step), .soft_rst(soft_rst),
    .state(state), .game_over(game_over), .game_won(game_won), .speed_lvl(speed_lvl)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    ncnt++;
    frame_done = (ncnt % 30 == 0);
    start_req = 1'b0;
    pause_req = 1'b0;
    if (step) begin
      last_step = ncnt;
      n_steps++;
    end
  endtask
  task automatic run_to(input int n);
    while (ncnt < n) tick();
  endtask
  initial begin
    int hi;
    run_to(2);
    check("rst_state", state, IDLE);
    check("rst_step", step, 0);
    check("rst_soft", soft_rst, 0);
    check("rst_over", game_over, 0);
    check("rst_won", game_won, 0);
    check("rst_lvl", speed_lvl, 0);
    reset = 1'b0;
    run_to(4);
    start_req = 1'b1;
    hi = 0;
    repeat (4) begin
      tick();
      hi += int'(soft_rst);
      check("clear_state", state, CLEAR);
    end
    check("clear_len", hi, 4);
    check("clear_nostep", n_steps, 0);
    tick();
    check("run_entry", state, RUN);
    check("run_softrst", soft_rst, 0);
    run_to(130);
    check("step1_time", last_step, 121);
    score = 8'd40;
    run_to(235);
    check("lvl_before", speed_lvl, 0);
    run_to(245);
    check("step2_time", last_step, 241);
    check("lvl_after", speed_lvl, 7);
    run_to(305);
    check("step3_floor", last_step, 301);
    score = 8'd136;
    run_to(365);
    check("step4_floor", last_step, 361);
    check("lvl_clamp", speed_lvl, 7);
    check("step_count", n_steps, 4);
    run_to(380);
    pause_req = 1'b1;
    tick();
    check("pause_state", state, PAUSE);
    run_to(500);
    check("pause_nostep", n_steps, 4);
    pause_req = 1'b1;
    tick();
    check("resume_state", state, RUN);
    run_to(545);
    check("resume_timer", last_step, 541);
    run_to(600);
    bad_coll = 1'b1;
    score = 8'd255;
    tick();
    bad_coll = 1'b0;
    check("over_state", state, OVER);
    check("over_flag", game_over, 1);
    check("over_notwon", game_won, 0);
    check("over_suppress", step, 0);
    run_to(660);
    check("over_nostep", n_steps, 5);
    check("over_hold", state, OVER);
    score = 8'd0;
    start_req = 1'b1;
    tick();
    check("restart_state", state, CLEAR);
    check("restart_over", game_over, 0);
    run_to(666);
    check("restart_lvl", speed_lvl, 0);
    run_to(775);
    reset = 1'b1;
    #1;
    check("arst_state", state, IDLE);
    check("arst_step", step, 0);
    check("arst_soft", soft_rst, 0);
    run_to(785);
    check("arst_nostep", n_steps, 5);
    reset = 1'b0;
    run_to(790);
    start_req = 1'b1;
    run_to(800);
    pause_req = 1'b1;
    tick();
    check("pause2", state, PAUSE);
    run_to(810);
    start_req = 1'b1;
    pause_req = 1'b1;
    tick();
    check("start_wins", state, CLEAR);
    run_to(820);
    start_req = 1'b1;
    tick();
    check("start_ignored", state, RUN);
    run_to(825);
    score = 8'd137;
    tick();
    check("win_state", state, WIN);
    check("win_flag", game_won, 1);
    check("win_notover", game_over, 0);
    score = 8'd0;
    run_to(830);
    start_req = 1'b1;
    run_to(840);
    bad_coll = 1'b1;
    tick();
    bad_coll = 1'b0;
    check("over2", state, OVER);
    run_to(4435);
    check("auto_wait", state, OVER);
    run_to(4441);
`ifdef SEQ_AUTO_RESTART_EN
    check("auto_restart", state, CLEAR);
`else
    check("auto_off", state, OVER);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
